// File: rtl/heater_pkg.sv
// Shared types, widths and helpers for the heater channel sequencer.
//   ctrl_state_t : sequencer FSM states
//   ERR_CNT_W    : width of the saturating error-cycle counter
//   MAX_CHAN     : largest supported channel count
//   thermo(n)    : thermometer mask with the lowest n bits set
package heater_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        SETTLE,
        RUN,
        RAMP_DOWN
    } ctrl_state_t;

    localparam int unsigned ERR_CNT_W  = 32;
    localparam int unsigned MAX_CHAN   = 64;
    localparam int unsigned CHAN_CNT_W = 7;

    // Thermometer mask: bit i set for every i < n.
    function automatic logic [MAX_CHAN-1:0] thermo(input logic [CHAN_CNT_W-1:0] n);
        logic [MAX_CHAN-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_CHAN; i++) begin
            m[i] = (CHAN_CNT_W'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/heater_step_timer.sv
// Reloadable down-counter producing a single-cycle expire pulse
// load_val cycles after load; shared by all timed sequencer phases.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : restart the count with load_val_i (load_val_i >= 1)
//   load_val_i  : cycles until expire
//   expire_o    : registered 1-cycle pulse; the consumer acts on the next
//                 edge, which lands exactly load_val cycles after the load
module heater_step_timer #(
    parameter int unsigned TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          expire_o
);

    logic [TW-1:0] cnt_q;
    logic          expire_q;

    // Count is preloaded with load_val-1 so the registered pulse is not late.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= load_val_i - TW'(1);
            expire_q <= (load_val_i == TW'(1));
        end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - TW'(1);
            expire_q <= (cnt_q == TW'(1));
        end else begin
            expire_q <= 1'b0;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/heater_ctrl.sv
// Heater channel sequencer: ramps channels out of reset one per step,
// settles, clears checkers, monitors errors, then ramps channels back down.
//   start / stop / target_chans : control (start in IDLE, stop while ramping/running)
//   clr_status                  : clear sticky errors and error count
//   chan_error                  : per-channel checker error (monitored in RUN only)
//   chan_reset, chan_err_clear  : per-channel reset and checker clear pulse
//   active_chans, running, busy : status
//   err_sticky, err_count       : sticky error flags, saturating error-cycle count
module heater_ctrl
    import heater_pkg::*;
#(
    parameter  int unsigned NUM_CHAN      = 8,
    parameter  int unsigned STEP_CYCLES   = 1024,
    parameter  int unsigned SETTLE_CYCLES = 4096,
    localparam int unsigned CW            = $clog2(NUM_CHAN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CW-1:0]        target_chans,
    input  logic                 clr_status,
    input  logic [NUM_CHAN-1:0]  chan_error,
    output logic [NUM_CHAN-1:0]  chan_reset,
    output logic [NUM_CHAN-1:0]  chan_err_clear,
    output logic [CW-1:0]        active_chans,
    output logic                 running,
    output logic                 busy,
    output logic [NUM_CHAN-1:0]  err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned MAX_CYC = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    ctrl_state_t          state_q;
    logic [CW-1:0]        active_q;
    logic [CW-1:0]        tgt_q;
    logic [NUM_CHAN-1:0]  chan_reset_q;
    logic [NUM_CHAN-1:0]  err_clr_q;
    logic                 running_q;
    logic                 busy_q;
    logic [NUM_CHAN-1:0]  sticky_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic                 step_expire;
    logic                 timer_load_c;
    logic [TW-1:0]        timer_val_c;
    logic [CW-1:0]        active_inc_c;
    logic [CW-1:0]        active_dec_c;
    logic [CW-1:0]        tgt_clamp_c;
    logic [NUM_CHAN-1:0]  hit_c;

    heater_step_timer #(
        .TW (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load_c),
        .load_val_i (timer_val_c),
        .expire_o   (step_expire)
    );

    // Arithmetic helpers for the FSM.
    always_comb begin
        active_inc_c = active_q + CW'(1);
        active_dec_c = active_q - CW'(1);
        tgt_clamp_c  = (target_chans > CW'(NUM_CHAN)) ? CW'(NUM_CHAN) : target_chans;
    end

    // Timer reload: on entry to each timed phase and after every step.
    always_comb begin
        timer_load_c = 1'b0;
        timer_val_c  = TW'(STEP_CYCLES);
        unique case (state_q)
            IDLE: begin
                timer_load_c = start && (target_chans != '0);
            end
            RAMP_UP: begin
                if (stop) begin
                    timer_load_c = (active_q != '0);
                end else if (step_expire) begin
                    timer_load_c = 1'b1;
                    if (active_inc_c == tgt_q) begin
                        timer_val_c = TW'(SETTLE_CYCLES);
                    end
                end
            end
            SETTLE, RUN: begin
                timer_load_c = stop;
            end
            RAMP_DOWN: begin
                timer_load_c = step_expire && (active_dec_c != '0);
            end
            default: begin
                timer_load_c = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            active_q     <= '0;
            tgt_q        <= '0;
            chan_reset_q <= '1;
            err_clr_q    <= '0;
            running_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            err_clr_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (start && (target_chans != '0)) begin
                        state_q <= RAMP_UP;
                        tgt_q   <= tgt_clamp_c;
                        busy_q  <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (stop) begin
                        // Nothing enabled yet: no ramp-down needed.
                        if (active_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RAMP_DOWN;
                        end
                    end else if (step_expire) begin
                        active_q     <= active_inc_c;
                        chan_reset_q <= ~NUM_CHAN'(thermo(CHAN_CNT_W'(active_inc_c)));
                        if (active_inc_c == tgt_q) begin
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        state_q <= RAMP_DOWN;
                    end else if (step_expire) begin
                        err_clr_q <= ~chan_reset_q;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    // running rises the cycle after the checker clear pulse.
                    if (stop) begin
                        state_q   <= RAMP_DOWN;
                        running_q <= 1'b0;
                    end else begin
                        running_q <= 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (step_expire) begin
                        active_q     <= active_dec_c;
                        chan_reset_q <= ~NUM_CHAN'(thermo(CHAN_CNT_W'(active_dec_c)));
                        if (active_dec_c == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Errors only count on active channels while monitoring.
    always_comb begin
        hit_c = running_q ? (chan_error & ~chan_reset_q) : '0;
    end

    // Sticky flags and saturating count; a new error wins over clr_status.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q    <= '0;
            err_count_q <= '0;
        end else begin
            sticky_q <= (clr_status ? '0 : sticky_q) | hit_c;
            if (clr_status) begin
                err_count_q <= (hit_c != '0) ? ERR_CNT_W'(1) : '0;
            end else if ((hit_c != '0) && (err_count_q != '1)) begin
                err_count_q <= err_count_q + ERR_CNT_W'(1);
            end
        end
    end

    assign chan_reset     = chan_reset_q;
    assign chan_err_clear = err_clr_q;
    assign active_chans   = active_q;
    assign running        = running_q;
    assign busy           = busy_q;
    assign err_sticky     = sticky_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_heater_ctrl.sv
// Directed bench for heater_ctrl (NUM_CHAN=4, STEP_CYCLES=4, SETTLE_CYCLES=8).
`timescale 1ns/1ps
module tb_heater_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [2:0]  target_chans;
    logic        clr_status;
    logic [3:0]  chan_error;
    logic [3:0]  chan_reset;
    logic [3:0]  chan_err_clear;
    logic [2:0]  active_chans;
    logic        running;
    logic        busy;
    logic [3:0]  err_sticky;
    logic [31:0] err_count;

    int tests;
    int fails;

    heater_ctrl #(
        .NUM_CHAN      (4),
        .STEP_CYCLES   (4),
        .SETTLE_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .target_chans   (target_chans),
        .clr_status     (clr_status),
        .chan_error     (chan_error),
        .chan_reset     (chan_reset),
        .chan_err_clear (chan_err_clear),
        .active_chans   (active_chans),
        .running        (running),
        .busy           (busy),
        .err_sticky     (err_sticky),
        .err_count      (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are held for ncyc edges, then outputs are checked 1ns after the last edge.
    typedef struct {
        string       name;
        int unsigned ncyc;
        logic        rs;
        logic        st;
        logic        sp;
        logic [2:0]  tg;
        logic        cl;
        logic [3:0]  er;
        logic [3:0]  x_rst;
        logic [3:0]  x_eclr;
        logic [2:0]  x_act;
        logic        x_run;
        logic        x_busy;
        logic [3:0]  x_sticky;
        logic [31:0] x_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string nm, int unsigned n, logic rs, logic st, logic sp,
                                logic [2:0] tg, logic cl, logic [3:0] er,
                                logic [3:0] xr, logic [3:0] xe, logic [2:0] xa,
                                logic xrun, logic xb, logic [3:0] xs, logic [31:0] xc);
        vec_t v;
        v.name = nm; v.ncyc = n; v.rs = rs; v.st = st; v.sp = sp; v.tg = tg;
        v.cl = cl; v.er = er; v.x_rst = xr; v.x_eclr = xe; v.x_act = xa;
        v.x_run = xrun; v.x_busy = xb; v.x_sticky = xs; v.x_cnt = xc;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [3:0] xr, input logic [3:0] xe,
                         input logic [2:0] xa, input logic xrun, input logic xb,
                         input logic [3:0] xs, input logic [31:0] xc);
        tests++;
        if (chan_reset !== xr || chan_err_clear !== xe || active_chans !== xa ||
            running !== xrun || busy !== xb || err_sticky !== xs || err_count !== xc) begin
            fails++;
            $display("FAIL %s: got rst=%b eclr=%b act=%0d run=%b busy=%b sticky=%b cnt=%h | want rst=%b eclr=%b act=%0d run=%b busy=%b sticky=%b cnt=%h",
                     nm, chan_reset, chan_err_clear, active_chans, running, busy, err_sticky, err_count,
                     xr, xe, xa, xrun, xb, xs, xc);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; stop = 1'b0; target_chans = 3'd0;
        clr_status = 1'b0; chan_error = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        reset = 1'b1;

        //  name            n   rs st sp tg    cl er       rst      eclr     act  run  busy sticky   cnt
        add("reset",        1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b0000, 32'd0);
        // Ramp-up to 3 channels.
        add("up_start",     1,  0, 1, 0, 3'd3, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b0000, 32'd0);
        add("up_wait1",     3,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b0000, 32'd0);
        add("up_ch0",       1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1110, 4'b0000, 3'd1, 0, 1, 4'b0000, 32'd0);
        add("up_ch1",       4,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1100, 4'b0000, 3'd2, 0, 1, 4'b0000, 32'd0);
        add("up_ch2",       4,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1000, 4'b0000, 3'd3, 0, 1, 4'b0000, 32'd0);
        add("settle_pre",   7,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1000, 4'b0000, 3'd3, 0, 1, 4'b0000, 32'd0);
        add("settle_clr",   1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1000, 4'b0111, 3'd3, 0, 1, 4'b0000, 32'd0);
        add("run_on",       1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1000, 4'b0000, 3'd3, 1, 1, 4'b0000, 32'd0);
        // Error capture.
        add("err_ch1_x5",   5,  0, 0, 0, 3'd0, 0, 4'b0010, 4'b1000, 4'b0000, 3'd3, 1, 1, 4'b0010, 32'd5);
        add("err_inactive", 3,  0, 0, 0, 3'd0, 0, 4'b1000, 4'b1000, 4'b0000, 3'd3, 1, 1, 4'b0010, 32'd5);
        add("clr_status",   1,  0, 0, 0, 3'd0, 1, 4'b0000, 4'b1000, 4'b0000, 3'd3, 1, 1, 4'b0000, 32'd0);
        add("clr_with_err", 1,  0, 0, 0, 3'd0, 1, 4'b0001, 4'b1000, 4'b0000, 3'd3, 1, 1, 4'b0001, 32'd1);
        add("err_ch2_x2",   2,  0, 0, 0, 3'd0, 0, 4'b0100, 4'b1000, 4'b0000, 3'd3, 1, 1, 4'b0101, 32'd3);
        // Ramp-down; errors ignored outside RUN.
        add("dn_stop",      1,  0, 0, 1, 3'd0, 0, 4'b0000, 4'b1000, 4'b0000, 3'd3, 0, 1, 4'b0101, 32'd3);
        add("dn_err_ign",   3,  0, 0, 0, 3'd0, 0, 4'b0011, 4'b1000, 4'b0000, 3'd3, 0, 1, 4'b0101, 32'd3);
        add("dn_ch2",       1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1100, 4'b0000, 3'd2, 0, 1, 4'b0101, 32'd3);
        add("dn_ch1",       4,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1110, 4'b0000, 3'd1, 0, 1, 4'b0101, 32'd3);
        add("dn_wait",      3,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1110, 4'b0000, 3'd1, 0, 1, 4'b0101, 32'd3);
        add("dn_ch0_idle",  1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b0101, 32'd3);
        add("clr_idle",     1,  0, 0, 0, 3'd0, 1, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b0000, 32'd0);
        // Target clamp; start outside IDLE ignored.
        add("clamp_start",  1,  0, 1, 0, 3'd7, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b0000, 32'd0);
        add("clamp_w2",     2,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b0000, 32'd0);
        add("start_busy",   1,  0, 1, 0, 3'd1, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b0000, 32'd0);
        add("clamp_ch0",    1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1110, 4'b0000, 3'd1, 0, 1, 4'b0000, 32'd0);
        add("clamp_all",   12,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0, 1, 4'b0000, 32'd0);
        add("clamp_settle", 7,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0, 1, 4'b0000, 32'd0);
        add("clamp_clr",    1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b1111, 3'd4, 0, 1, 4'b0000, 32'd0);
        add("clamp_run",    1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 1, 1, 4'b0000, 32'd0);
        add("err_ch3",      1,  0, 0, 0, 3'd0, 0, 4'b1000, 4'b0000, 4'b0000, 3'd4, 1, 1, 4'b1000, 32'd1);
        add("clamp_stop",   1,  0, 0, 1, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0, 1, 4'b1000, 32'd1);
        add("clamp_dn_w2",  2,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0, 1, 4'b1000, 32'd1);
        add("stop_in_dn",   1,  0, 0, 1, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0, 1, 4'b1000, 32'd1);
        add("clamp_dn3",    1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1000, 4'b0000, 3'd3, 0, 1, 4'b1000, 32'd1);
        add("clamp_dn0",   12,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b1000, 32'd1);
        // Ignore rules and early stop.
        add("tgt0_ign",     1,  0, 1, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b1000, 32'd1);
        add("tgt0_wait",    8,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b1000, 32'd1);
        add("stop_idle",    1,  0, 0, 1, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b1000, 32'd1);
        add("start_stop",   1,  0, 1, 1, 3'd2, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b1000, 32'd1);
        add("early_w1",     1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b1000, 32'd1);
        add("early_stop",   1,  0, 0, 1, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b1000, 32'd1);
        add("early_after",  8,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b1000, 32'd1);
        // Mid-ramp reset and restart.
        add("mr_start",     1,  0, 1, 0, 3'd4, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b1000, 32'd1);
        add("mr_two_up",    8,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1100, 4'b0000, 3'd2, 0, 1, 4'b1000, 32'd1);
        add("mr_reset",     1,  1, 0, 0, 3'd0, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 0, 4'b0000, 32'd0);
        add("rs_start",     1,  0, 1, 0, 3'd2, 0, 4'b0000, 4'b1111, 4'b0000, 3'd0, 0, 1, 4'b0000, 32'd0);
        add("rs_ch0",       4,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1110, 4'b0000, 3'd1, 0, 1, 4'b0000, 32'd0);
        add("rs_ch1",       4,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1100, 4'b0000, 3'd2, 0, 1, 4'b0000, 32'd0);
        add("rs_settle",    7,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1100, 4'b0000, 3'd2, 0, 1, 4'b0000, 32'd0);
        add("rs_clr",       1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1100, 4'b0011, 3'd2, 0, 1, 4'b0000, 32'd0);
        add("rs_run",       1,  0, 0, 0, 3'd0, 0, 4'b0000, 4'b1100, 4'b0000, 3'd2, 1, 1, 4'b0000, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vq[k]) begin
            reset        = vq[k].rs;
            start        = vq[k].st;
            stop         = vq[k].sp;
            target_chans = vq[k].tg;
            clr_status   = vq[k].cl;
            chan_error   = vq[k].er;
            repeat (vq[k].ncyc) @(posedge clk);
            #1;
            idle_inputs();
            check(vq[k].name, vq[k].x_rst, vq[k].x_eclr, vq[k].x_act, vq[k].x_run,
                  vq[k].x_busy, vq[k].x_sticky, vq[k].x_cnt);
        end

        // Saturation: preload the counter just below the ceiling.
        force dut.err_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_count_q;
        chan_error = 4'b0001;
        @(posedge clk);
        #1;
        check("sat_first", 4'b1100, 4'b0000, 3'd2, 1'b1, 1'b1, 4'b0001, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        chan_error = 4'b0000;
        check("sat_hold", 4'b1100, 4'b0000, 3'd2, 1'b1, 1'b1, 4'b0001, 32'hFFFF_FFFF);
        clr_status = 1'b1;
        @(posedge clk);
        #1;
        clr_status = 1'b0;
        check("sat_clear", 4'b1100, 4'b0000, 3'd2, 1'b1, 1'b1, 4'b0000, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
